// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage between EX and WB.
// Loads wait in this stage for a variable-latency data_sram response, then the
// captured word is byte/half/word extended from the low address bits. A
// forwarding port tells decode when a load in this stage has no data yet.
module mem_stage_lsu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_load_op,
  input  logic              es_gr_we,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              data_rsp_valid,
  input  logic [DATA_W-1:0] data_rsp_rdata,
  output logic              ms_to_ws_valid,
  output logic              ms_gr_we,
  output logic [REG_AW-1:0] ms_dest,
  output logic [DATA_W-1:0] ms_final_result,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_fwd_valid,
  output logic [REG_AW-1:0] ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_data,
  output logic              ms_fwd_pending
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLb  = 3'd1;
  localparam logic [2:0] OpLbu = 3'd2;
  localparam logic [2:0] OpLh  = 3'd3;
  localparam logic [2:0] OpLhu = 3'd4;

  typedef enum logic [0:0] {StReady, StWait} state_t;

  state_t              state_q, state_d;
  logic                ms_valid_q;
  logic                res_from_mem_q;
  logic [2:0]          load_op_q;
  logic                gr_we_q;
  logic [REG_AW-1:0]   dest_q;
  logic [DATA_W-1:0]   alu_result_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   data_q;

  logic                ready_go;
  logic                accept;
  logic                capture;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   final_result;

  assign accept  = es_to_ms_valid & ms_allowin;
  // Responses outside WAIT are strays and must not disturb the captured data.
  assign capture = (state_q == StWait) & data_rsp_valid;

  // Valid bit advances whenever the stage can take from EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_to_ms_valid;
    end
  end

  // Instruction payload latched on an accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_from_mem_q <= 1'b0;
      load_op_q      <= 3'd0;
      gr_we_q        <= 1'b0;
      dest_q         <= '0;
      alu_result_q   <= '0;
      pc_q           <= '0;
    end else if (accept) begin
      res_from_mem_q <= es_res_from_mem;
      load_op_q      <= es_load_op;
      gr_we_q        <= es_gr_we;
      dest_q         <= es_dest;
      alu_result_q   <= es_alu_result;
      pc_q           <= es_pc;
    end
  end

  // Captured load data, held until the next response in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= data_rsp_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReady;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a newly accepted instruction decides; otherwise WAIT ends on a response.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = es_res_from_mem ? StWait : StReady;
    end else if (capture) begin
      state_d = StReady;
    end
  end

  // State-derived outputs.
  always_comb begin
    ready_go       = ms_valid_q & (state_q == StReady);
    ms_fwd_pending = ms_valid_q & res_from_mem_q & (state_q == StWait);
  end

  // Byte/half select and extension; addr[0] is ignored for halves.
  always_comb begin
    ld_byte = data_q[{alu_result_q[1:0], 3'b000} +: 8];
    ld_half = data_q[{alu_result_q[1], 4'b0000} +: 16];
    case (load_op_q)
      OpLb:    load_ext = {{(DATA_W - 8){ld_byte[7]}}, ld_byte};
      OpLbu:   load_ext = {{(DATA_W - 8){1'b0}}, ld_byte};
      OpLh:    load_ext = {{(DATA_W - 16){ld_half[15]}}, ld_half};
      OpLhu:   load_ext = {{(DATA_W - 16){1'b0}}, ld_half};
      OpLw:    load_ext = data_q;
      default: load_ext = data_q;
    endcase
    final_result = res_from_mem_q ? load_ext : alu_result_q;
  end

  // Handshake, WB and forwarding outputs.
  always_comb begin
    ms_allowin      = ~ms_valid_q | (ready_go & ws_allowin);
    ms_to_ws_valid  = ready_go;
    ms_gr_we        = gr_we_q;
    ms_dest         = dest_q;
    ms_final_result = final_result;
    ms_pc           = pc_q;
    ms_fwd_valid    = ms_valid_q & gr_we_q;
    ms_fwd_dest     = dest_q;
    ms_fwd_data     = final_result;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed sequences, a load-extension
// vector table, and randomized traffic against a transaction-level model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_alu_result;
  logic [31:0] es_pc;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_rdata;
  logic        ms_to_ws_valid;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic [31:0] ms_pc;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_pending;

  mem_stage_lsu #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_res_from_mem (es_res_from_mem),
    .es_load_op      (es_load_op),
    .es_gr_we        (es_gr_we),
    .es_dest         (es_dest),
    .es_alu_result   (es_alu_result),
    .es_pc           (es_pc),
    .data_rsp_valid  (data_rsp_valid),
    .data_rsp_rdata  (data_rsp_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_gr_we        (ms_gr_we),
    .ms_dest         (ms_dest),
    .ms_final_result (ms_final_result),
    .ms_pc           (ms_pc),
    .ms_fwd_valid    (ms_fwd_valid),
    .ms_fwd_dest     (ms_fwd_dest),
    .ms_fwd_data     (ms_fwd_data),
    .ms_fwd_pending  (ms_fwd_pending)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level model: one slot that is either empty, holding a result,
  // or holding a load still waiting for its data word.
  logic        m_occ, m_wait, m_load, m_we;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;
  logic [31:0] m_alu, m_pc, m_data;
  int          wcnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ext_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load extension from arithmetic on the word: pick a lane, then sign or zero fill.
  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * int'(addr[1:0]))) % 256;
    h = (d >> (16 * int'(addr[1]))) % 65536;
    case (op)
      3'd1:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd2:    return 32'(b);
      3'd3:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd4:    return 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic logic exp_ready();
    return m_occ & ~m_wait;
  endfunction

  function automatic logic exp_allowin();
    return ~m_occ | (exp_ready() & ws_allowin);
  endfunction

  task automatic compare_model();
    check("allowin", 32'(ms_allowin), 32'(exp_allowin()));
    check("to_ws_valid", 32'(ms_to_ws_valid), 32'(exp_ready()));
    check("fwd_pending", 32'(ms_fwd_pending), 32'(m_occ & m_load & m_wait));
    check("fwd_valid", 32'(ms_fwd_valid), 32'(m_occ & m_we));
    if (exp_ready()) begin
      check("final_result", ms_final_result, m_load ? extend(m_op, m_alu, m_data) : m_alu);
      check("fwd_data", ms_fwd_data, m_load ? extend(m_op, m_alu, m_data) : m_alu);
      check("pc", ms_pc, m_pc);
      check("dest", 32'(ms_dest), 32'(m_dest));
      check("fwd_dest", 32'(ms_fwd_dest), 32'(m_dest));
      check("gr_we", 32'(ms_gr_we), 32'(m_we));
    end
  endtask

  task automatic update_model();
    logic allow;
    allow = exp_allowin();
    if (reset) begin
      m_occ = 0; m_wait = 0; m_load = 0; m_we = 0; m_op = 0;
      m_dest = 0; m_alu = 0; m_pc = 0; m_data = 0;
    end else begin
      if (m_occ && m_wait && data_rsp_valid) begin
        m_data = data_rsp_rdata;
        m_wait = 0;
      end
      if (allow) begin
        m_occ = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_load = es_res_from_mem; m_op = es_load_op; m_we = es_gr_we;
          m_dest = es_dest; m_alu = es_alu_result; m_pc = es_pc;
          m_wait = es_res_from_mem;
          if (es_res_from_mem) wcnt = $urandom_range(0, 3);
        end
      end
    end
  endtask

  // Inputs are already stable; compare, take the edge, then settle.
  task automatic tick();
    #1;
    compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic [2:0] op, input logic we,
                       input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc);
    es_to_ms_valid = v; es_res_from_mem = ld; es_load_op = op; es_gr_we = we;
    es_dest = d; es_alu_result = alu; es_pc = pc;
  endtask

  ext_vec_t vecs[8];

  initial begin
    vecs[0] = '{3'd1, 32'h0000_0003, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[1] = '{3'd2, 32'h0000_0002, 32'h80FF_7F01, 32'h0000_00FF};
    vecs[2] = '{3'd3, 32'h0000_0002, 32'h80FF_7F01, 32'hFFFF_80FF};
    vecs[3] = '{3'd4, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_7F01};
    vecs[4] = '{3'd1, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_007F};
    vecs[5] = '{3'd4, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_80FF};
    vecs[6] = '{3'd7, 32'h0000_0001, 32'h80FF_7F01, 32'h80FF_7F01};
    vecs[7] = '{3'd3, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_7F01};

    reset = 1; ws_allowin = 1; data_rsp_valid = 0; data_rsp_rdata = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    update_model();
    #1;
    tick();
    check("rst_to_ws_valid", 32'(ms_to_ws_valid), 0);
    check("rst_fwd_valid", 32'(ms_fwd_valid), 0);
    check("rst_fwd_pending", 32'(ms_fwd_pending), 0);
    check("rst_allowin", 32'(ms_allowin), 1);
    reset = 0;

    // Non-load passes through with one cycle of latency.
    drive(1, 0, 0, 1, 5'd5, 32'h1234, 32'h1000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t1_valid", 32'(ms_to_ws_valid), 1);
    check("t1_result", ms_final_result, 32'h1234);
    check("t1_fwd_valid", 32'(ms_fwd_valid), 1);
    check("t1_pending", 32'(ms_fwd_pending), 0);
    tick();

    // LW with response in the third waiting cycle.
    drive(1, 1, 3'd0, 1, 5'd7, 32'h100, 32'h1000_0004);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t2_pending", 32'(ms_fwd_pending), 1);
      check("t2_allowin", 32'(ms_allowin), 0);
      check("t2_valid_early", 32'(ms_to_ws_valid), 0);
      data_rsp_valid = (i == 2);
      data_rsp_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      tick();
    end
    data_rsp_valid = 0;
    check("t2_valid", 32'(ms_to_ws_valid), 1);
    check("t2_result", ms_final_result, 32'hDEAD_BEEF);
    check("t2_pending_done", 32'(ms_fwd_pending), 0);
    tick();

    // Extension table.
    foreach (vecs[k]) begin
      drive(1, 1, vecs[k].op, 1, 5'd9, vecs[k].addr, 32'h2000_0000 + 32'(k));
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      data_rsp_valid = 1; data_rsp_rdata = vecs[k].rdata;
      tick();
      data_rsp_valid = 0;
      check($sformatf("ext%0d", k), ms_final_result, vecs[k].exp);
      tick();
    end

    // Captured load held while WB stalls, then next instruction taken the same edge.
    drive(1, 1, 3'd2, 1, 5'd3, 32'h201, 32'h3000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    ws_allowin = 0;
    data_rsp_valid = 1; data_rsp_rdata = 32'h1122_AB44;
    tick();
    data_rsp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", 32'(ms_to_ws_valid), 1);
      check("t4_hold_allowin", 32'(ms_allowin), 0);
      check("t4_hold_result", ms_final_result, 32'h0000_00AB);
      data_rsp_valid = (i == 1); data_rsp_rdata = 32'hFFFF_FFFF;
      tick();
    end
    data_rsp_valid = 0;
    ws_allowin = 1;
    drive(1, 0, 0, 1, 5'd4, 32'h55, 32'h3000_0004);
    #1;
    check("t4_allowin", 32'(ms_allowin), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4_next_result", ms_final_result, 32'h55);
    check("t4_next_pc", ms_pc, 32'h3000_0004);
    tick();

    // Stray response during a non-load is ignored.
    drive(1, 0, 0, 1, 5'd6, 32'hABCD, 32'h4000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    ws_allowin = 0; data_rsp_valid = 1; data_rsp_rdata = 32'h999;
    tick();
    data_rsp_valid = 0;
    check("t5_stray_result", ms_final_result, 32'hABCD);
    ws_allowin = 1;
    tick();
    // Reset while a load waits drops it; a later response is ignored.
    drive(1, 1, 3'd0, 1, 5'd8, 32'h40, 32'h4000_0004);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    check("t5_rst_valid", 32'(ms_to_ws_valid), 0);
    check("t5_rst_pending", 32'(ms_fwd_pending), 0);
    data_rsp_valid = 1; data_rsp_rdata = 32'h7777_7777;
    tick();
    data_rsp_valid = 0;
    check("t5_stray_valid", 32'(ms_to_ws_valid), 0);
    check("t5_stray_allowin", 32'(ms_allowin), 1);

    // Back-to-back non-loads: one result per cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 1, 5'(i + 10), 32'h500 + 32'(i), 32'h5000_0000 + 32'(4 * i));
      tick();
      check("t6_valid", 32'(ms_to_ws_valid), 1);
      check("t6_result", ms_final_result, 32'h500 + 32'(i));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      ws_allowin = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom);
      data_rsp_rdata = $urandom;
      if (m_occ && m_wait) begin
        data_rsp_valid = (wcnt == 0);
        if (wcnt > 0) wcnt--;
      end else begin
        data_rsp_valid = ($urandom_range(0, 4) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
